box_shape_drawer: RTL and testbench
===================================

Name: box_shape_drawer

Overview:
Pixel-plotting responder for the display controller FSM's shape handshake. Latches a box start address on load_start, then on start_draw rasters a BOX_W x BOX_H rectangle, one pixel per clock, into the VGA adapter's plot interface. Pulses shape_done on completion so the controller can advance to the next box or return to waiting for the song. Sits between the display controller FSM and the VGA adapter, in parallel with the default-background writer.

Parameters:
SCREEN_W, 240, visible width in pixels
SCREEN_H, 180, visible height in pixels
BOX_W, 40, box width in pixels
BOX_H, 10, box height in pixels
LANE_X0, 20, x of box 0's left edge
LANE_PITCH, 60, x distance between adjacent lanes
COLOUR_W, 3, colour bits per pixel

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
load_start  in  1  latch box_index, y_start, note_on (controller "load start address")
box_index  in  2  lane 0..3
y_start  in  8  top row of box
note_on  in  1  1 = note colour, 0 = background colour
note_colour  in  COLOUR_W  fill colour when note_on=1
bg_colour  in  COLOUR_W  fill colour when note_on=0
start_draw  in  1  begin drawing latched box (controller "starting address loaded")
plot  out  1  pixel write strobe to VGA adapter
x_out  out  8  pixel x
y_out  out  8  pixel y
colour_out  out  COLOUR_W  pixel colour
busy  out  1  high in ARMED or DRAW
shape_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high; clock clock): state IDLE; plot, shape_done, busy, x_out, y_out, colour_out = 0; latched address cleared; no shape_done issued for an aborted draw.
- States: IDLE, ARMED, DRAW, DONE.
- IDLE: load_start=1 -> latch base_x = LANE_X0 + box_index*LANE_PITCH (9-bit internal), base_y = y_start, colour = note_on ? note_colour : bg_colour; go ARMED. start_draw alone ignored.
- ARMED: load_start=1 re-latches and stays ARMED. start_draw=1 -> clear offsets dx=dy=0; go DRAW. If both are asserted in the same cycle, the load wins: re-latch, stay ARMED.
- DRAW: each cycle drive x_out = base_x+dx, y_out = base_y+dy, colour_out = latched colour.
  - plot=1 unless clipped.
  - Raster order: dx increments; at dx = BOX_W-1, dx wraps to 0 and dy increments.
  - After the pixel (BOX_W-1, BOX_H-1) -> DONE.
  - load_start and start_draw ignored.
- Latency: first plot in the cycle after start_draw is sampled. Exactly BOX_W*BOX_H DRAW cycles.
- DONE: shape_done=1 for exactly one cycle, plot=0 -> IDLE. busy=0 in DONE.
- Clipping: a pixel with x >= SCREEN_W or y >= SCREEN_H has plot=0 but still consumes its cycle. Pixel count and timing are unchanged.
- Coordinate arithmetic is 9-bit. x_out/y_out are the low 8 bits and are only meaningful when plot=1.
- Outputs are registered. plot, x_out, y_out and colour_out change together.
- Reset mid-DRAW: abort, IDLE next cycle, plot=0, no shape_done.

Optional Feature:
SHAPE_BORDER_EN.
- Defined: pixels with dx=0, dx=BOX_W-1, dy=0 or dy=BOX_H-1 use package constant BORDER_COLOUR; interior pixels use the latched colour.
- Undefined: every pixel uses the latched colour.
- Timing and plot count are identical in both builds.

Decomposition:
- display_pkg holds:
  - SCREEN_W/SCREEN_H defaults, COLOUR_W
  - BORDER_COLOUR, default background colour
  - state enum type for IDLE/ARMED/DRAW/DONE
  - lane geometry constants
- One sub-module: pixel_scan_counter (parameters W, H). Inputs: clear, enable. Outputs: dx, dy, last. Holds the raster offset counter with row wrap.

Test Plan:
- load_start with box_index=0, y_start=5, note_on=1, note_colour=3'b100; then start_draw -> 400 consecutive plot cycles. First pixel (20,5), 41st pixel (20,6), last (59,14), all colour 4. shape_done high for one cycle immediately after.
- box_index=3, y_start=175 -> base_x=200. Pixels with y in 175..179 plot, y 180..184 have plot=0. Total still 400 cycles, then shape_done.
- start_draw with no prior load_start -> no plot, busy=0, no shape_done. Load index 1, y=0, then load index 2, y=0, then start_draw -> first pixel (140,0).
- Assert reset on DRAW cycle 100 -> plot=0 next cycle, shape_done never pulses, busy=0. A new load plus draw then works normally.
- Pulse load_start and start_draw in the same cycle while ARMED -> stay ARMED with the new address; no plot until a later start_draw.
- SHAPE_BORDER_EN build, index 0, y 0, note_colour=2 -> pixel (20,0) and (59,9) use BORDER_COLOUR; pixel (21,1) uses 2.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display geometry, colour constants and the box drawer state type.
// SHAPE_BORDER_EN (optional macro) makes box_shape_drawer paint box edges in BORDER_COLOUR.
package display_pkg;

  localparam int unsigned DEFAULT_SCREEN_W   = 240;
  localparam int unsigned DEFAULT_SCREEN_H   = 180;
  localparam int unsigned DEFAULT_BOX_W      = 40;
  localparam int unsigned DEFAULT_BOX_H      = 10;
  localparam int unsigned DEFAULT_LANE_X0    = 20;
  localparam int unsigned DEFAULT_LANE_PITCH = 60;
  localparam int unsigned PIXEL_COLOUR_W     = 3;
  localparam int unsigned COORD_W            = 9;

  localparam logic [PIXEL_COLOUR_W-1:0] BORDER_COLOUR     = 3'b111;
  localparam logic [PIXEL_COLOUR_W-1:0] DEFAULT_BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StDraw,
    StDone
  } drawState_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster offset counter: dx runs 0..W-1, then wraps and bumps dy; last flags (W-1, H-1).
module pixel_scan_counter #(
  parameter int unsigned W = 40,
  parameter int unsigned H = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [$clog2(W)-1:0] dx,
  output logic [$clog2(H)-1:0] dy,
  output logic                 last
);

  localparam int unsigned DxW = $clog2(W);
  localparam int unsigned DyW = $clog2(H);
  localparam logic [DxW-1:0] DxMax = DxW'(W - 1);
  localparam logic [DyW-1:0] DyMax = DyW'(H - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      dx <= '0;
      dy <= '0;
    end else if (enable) begin
      if (dx == DxMax) begin
        dx <= '0;
        dy <= (dy == DyMax) ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

  always_comb begin
    last = (dx == DxMax) && (dy == DyMax);
  end

endmodule

// File: rtl/box_shape_drawer.sv
// Rasters one lane box into the VGA plot interface, one pixel per clock, then pulses shape_done.
// Build with SHAPE_BORDER_EN defined to draw the box outline in BORDER_COLOUR.
module box_shape_drawer
  import display_pkg::*;
#(
  parameter int unsigned SCREEN_W   = DEFAULT_SCREEN_W,
  parameter int unsigned SCREEN_H   = DEFAULT_SCREEN_H,
  parameter int unsigned BOX_W      = DEFAULT_BOX_W,
  parameter int unsigned BOX_H      = DEFAULT_BOX_H,
  parameter int unsigned LANE_X0    = DEFAULT_LANE_X0,
  parameter int unsigned LANE_PITCH = DEFAULT_LANE_PITCH,
  parameter int unsigned COLOUR_W   = PIXEL_COLOUR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_start,
  input  logic [1:0]          box_index,
  input  logic [7:0]          y_start,
  input  logic                note_on,
  input  logic [COLOUR_W-1:0] note_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                start_draw,
  output logic                plot,
  output logic [7:0]          x_out,
  output logic [7:0]          y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                busy,
  output logic                shape_done
);

  localparam int unsigned DxW = $clog2(BOX_W);
  localparam int unsigned DyW = $clog2(BOX_H);

  drawState_e          state;
  logic [COORD_W-1:0]  baseX;
  logic [7:0]          baseY;
  logic [COLOUR_W-1:0] fillColour;
  logic                lastShown;

  logic [DxW-1:0]      dx;
  logic [DyW-1:0]      dy;
  logic                scanLast;
  logic                scanClear;
  logic                scanEnable;
  logic                startNow;

  logic [COORD_W-1:0]  latchX;
  logic [COORD_W-1:0]  pixX;
  logic [COORD_W-1:0]  pixY;
  logic                pixPlot;
  logic [COLOUR_W-1:0] pixColour;

  // The counter always holds the offset of the pixel emitted on the next edge.
  pixel_scan_counter #(
    .W (BOX_W),
    .H (BOX_H)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .clear  (scanClear),
    .enable (scanEnable),
    .dx     (dx),
    .dy     (dy),
    .last   (scanLast)
  );

  always_comb begin
    startNow   = (state == StArmed) && start_draw && !load_start;
    scanEnable = startNow || ((state == StDraw) && !lastShown);
    scanClear  = (state != StDraw) && !startNow;

    latchX  = COORD_W'(LANE_X0) + COORD_W'(box_index) * COORD_W'(LANE_PITCH);
    pixX    = baseX + COORD_W'(dx);
    pixY    = {1'b0, baseY} + COORD_W'(dy);
    pixPlot = (pixX < COORD_W'(SCREEN_W)) && (pixY < COORD_W'(SCREEN_H));
  end

`ifdef SHAPE_BORDER_EN
  logic onBorder;

  always_comb begin
    onBorder  = (dx == '0) || (dx == DxW'(BOX_W - 1)) || (dy == '0) || (dy == DyW'(BOX_H - 1));
    pixColour = onBorder ? COLOUR_W'(BORDER_COLOUR) : fillColour;
  end
`else
  always_comb begin
    pixColour = fillColour;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      baseX      <= '0;
      baseY      <= '0;
      fillColour <= '0;
      lastShown  <= 1'b0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      shape_done <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StArmed: begin
          plot       <= 1'b0;
          shape_done <= 1'b0;
          if (load_start) begin
            baseX      <= latchX;
            baseY      <= y_start;
            fillColour <= note_on ? note_colour : bg_colour;
            state      <= StArmed;
          end else if (startNow) begin
            plot       <= pixPlot;
            x_out      <= pixX[7:0];
            y_out      <= pixY[7:0];
            colour_out <= pixColour;
            lastShown  <= scanLast;
            state      <= StDraw;
          end
        end
        StDraw: begin
          if (lastShown) begin
            plot       <= 1'b0;
            shape_done <= 1'b1;
            lastShown  <= 1'b0;
            state      <= StDone;
          end else begin
            plot       <= pixPlot;
            x_out      <= pixX[7:0];
            y_out      <= pixY[7:0];
            colour_out <= pixColour;
            lastShown  <= scanLast;
          end
        end
        StDone: begin
          shape_done <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy = (state == StArmed) || (state == StDraw);
  end

endmodule

// File: tb/tb_box_shape_drawer.sv
// Directed bench for box_shape_drawer: expected pixels queued at start_draw, checked per cycle.
module tb_box_shape_drawer;

  localparam int SCR_W = 240;
  localparam int SCR_H = 180;
  localparam int BW    = 40;
  localparam int BH    = 10;
  localparam int LX0   = 20;
  localparam int LPIT  = 60;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
    bit         last;
  } pix_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic [1:0] box_index = '0;
  logic [7:0] y_start = '0;
  logic       note_on = 1'b0;
  logic [2:0] note_colour = '0;
  logic [2:0] bg_colour = 3'd1;
  logic       start_draw = 1'b0;
  logic       plot;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [2:0] colour_out;
  logic       busy;
  logic       shape_done;

  pix_t expQ[$];
  int   nCompared = 0;
  int   nMismatch = 0;
  bit   monOn = 1'b0;
  bit   doneDue = 1'b0;

  box_shape_drawer dut (
    .clock       (clock),
    .reset       (reset),
    .load_start  (load_start),
    .box_index   (box_index),
    .y_start     (y_start),
    .note_on     (note_on),
    .note_colour (note_colour),
    .bg_colour   (bg_colour),
    .start_draw  (start_draw),
    .plot        (plot),
    .x_out       (x_out),
    .y_out       (y_out),
    .colour_out  (colour_out),
    .busy        (busy),
    .shape_done  (shape_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected raster for one box; clipped pixels expect plot=0.
  task automatic pushBox(input int bx, input int by, input logic [2:0] col);
    pix_t it;
    for (int r = 0; r < BH; r++) begin
      for (int c = 0; c < BW; c++) begin
        it.plot = ((bx + c) < SCR_W) && ((by + r) < SCR_H);
        it.x    = 8'(bx + c);
        it.y    = 8'(by + r);
`ifdef SHAPE_BORDER_EN
        it.c    = (c == 0 || c == BW - 1 || r == 0 || r == BH - 1) ?
                  display_pkg::BORDER_COLOUR : col;
`else
        it.c    = col;
`endif
        it.last = (c == BW - 1) && (r == BH - 1);
        expQ.push_back(it);
      end
    end
  endtask

  task automatic loadBox(input logic [1:0] idx, input logic [7:0] y, input logic on,
                         input logic [2:0] nc);
    box_index   = idx;
    y_start     = y;
    note_on     = on;
    note_colour = nc;
    load_start  = 1'b1;
    @(posedge clock);
    #1 load_start = 1'b0;
  endtask

  task automatic startDraw(input int bx, input int by, input logic [2:0] col);
    start_draw = 1'b1;
    @(posedge clock);
    #1 start_draw = 1'b0;
    pushBox(bx, by, col);
  endtask

  task automatic waitDone(input string tag);
    bit timedOut;
    timedOut = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock);
      if (expQ.size() == 0 && !doneDue) begin
        timedOut = 1'b0;
        break;
      end
    end
    #1;
    check({tag, "_timeout"}, 32'(timedOut), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  // Per-cycle monitor on the falling edge.
  always @(negedge clock) begin
    pix_t it;
    bit   popped;
    popped = 1'b0;
    if (monOn) begin
      if (expQ.size() > 0) begin
        it     = expQ.pop_front();
        popped = 1'b1;
        check("plot", 32'(plot), 32'(it.plot));
        if (it.plot) begin
          check("x_out", 32'(x_out), 32'(it.x));
          check("y_out", 32'(y_out), 32'(it.y));
          check("colour_out", 32'(colour_out), 32'(it.c));
        end
      end else begin
        check("plot_quiet", 32'(plot), 0);
      end
      check("shape_done", 32'(shape_done), 32'(doneDue));
      doneDue = popped && it.last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(shape_done), 0);
    check("rst_x", 32'(x_out), 0);
    check("rst_y", 32'(y_out), 0);
    check("rst_colour", 32'(colour_out), 0);
    reset = 1'b0;
    monOn = 1'b1;

    // Lane 0, note colour 4.
    loadBox(2'd0, 8'd5, 1'b1, 3'b100);
    check("t1_busy_armed", 32'(busy), 1);
    startDraw(LX0, 5, 3'b100);
    check("t1_busy_draw", 32'(busy), 1);
    waitDone("t1");

    // Lane 3 near the bottom edge: rows 180..184 clipped.
    loadBox(2'd3, 8'd175, 1'b1, 3'b010);
    startDraw(LX0 + 3 * LPIT, 175, 3'b010);
    waitDone("t2");

    // start_draw alone in IDLE is ignored.
    start_draw = 1'b1;
    @(posedge clock);
    #1 start_draw = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("t3_busy_ignored", 32'(busy), 0);
    loadBox(2'd1, 8'd0, 1'b1, 3'b011);
    loadBox(2'd2, 8'd0, 1'b1, 3'b011);
    startDraw(LX0 + 2 * LPIT, 0, 3'b011);
    waitDone("t3");

    // Reset during DRAW cycle 100.
    loadBox(2'd0, 8'd30, 1'b1, 3'b101);
    startDraw(LX0, 30, 3'b101);
    repeat (100) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    expQ.delete();
    reset = 1'b0;
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_plot", 32'(plot), 0);
    repeat (5) @(posedge clock);
    #1 check("t4_idle_busy", 32'(busy), 0);
    loadBox(2'd1, 8'd20, 1'b0, 3'b110);
    startDraw(LX0 + LPIT, 20, 3'd1);
    waitDone("t4_redraw");

    // load_start and start_draw together while ARMED: load wins.
    loadBox(2'd1, 8'd50, 1'b1, 3'b001);
    box_index   = 2'd2;
    y_start     = 8'd60;
    note_colour = 3'b110;
    load_start  = 1'b1;
    start_draw  = 1'b1;
    @(posedge clock);
    #1;
    load_start = 1'b0;
    start_draw = 1'b0;
    check("t5_busy_armed", 32'(busy), 1);
    repeat (4) @(posedge clock);
    #1 check("t5_still_armed", 32'(busy), 1);
    startDraw(LX0 + 2 * LPIT, 60, 3'b110);
    waitDone("t5");

    // Lane 0 at the top, note colour 2 (outline differs in the border build).
    loadBox(2'd0, 8'd0, 1'b1, 3'b010);
    startDraw(LX0, 0, 3'b010);
    waitDone("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
